// File: rtl/io_responder.sv
// Memory-mapped I/O responder: SEG/LED write registers, switch/button readback with
// debounced buttons and clear-on-read press events, and an 8-digit 7-segment scanner.

module io_responder_btn #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        // Any sample that agrees with the accepted level restarts the run
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db   = db_q;
    assign btn_rise = db_d & ~db_q;
endmodule

module io_responder #(
    parameter int SCAN_CYCLES     = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    input  logic [23:0] device_sw,
    input  logic [4:0]  device_button,
    output logic [23:0] device_led,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out
);
    localparam int NUM_BTN = 5;
    localparam int SW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_CYCLES - 1);

    localparam logic [31:0] A_SEG    = 32'hFFFF_F000;
    localparam logic [31:0] A_LED_LO = 32'hFFFF_F060;
    localparam logic [31:0] A_LED_HI = 32'hFFFF_F062;
    localparam logic [31:0] A_SW     = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN    = 32'hFFFF_F078;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
        endcase
    endfunction

    logic [NUM_BTN-1:0] btn_db, btn_rise;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        io_responder_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw  (device_button[i]),
            .btn_db   (btn_db[i]),
            .btn_rise (btn_rise[i])
        );
    end

    logic               sel_seg, sel_led_lo, sel_led_hi, sel_sw, sel_btn, btn_rd;
    logic [31:0]        seg_q, seg_d;
    logic [23:0]        led_q, led_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [NUM_BTN-1:0] evt_q, evt_d;
    logic [SW-1:0]      scan_cnt_q, scan_cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         seg_en_q, seg_en_d;
    logic [7:0]         seg_out_q, seg_out_d;

    assign sel_seg    = (addr == A_SEG);
    assign sel_led_lo = (addr == A_LED_LO);
    assign sel_led_hi = (addr == A_LED_HI);
    assign sel_sw     = (addr == A_SW);
    assign sel_btn    = (addr == A_BTN);
    assign hit        = sel_seg | sel_led_lo | sel_led_hi | sel_sw | sel_btn;
    assign btn_rd     = sel_btn & ~wen;

    always_comb begin
        seg_d = seg_q;
        led_d = led_q;
        if (wen && sel_seg)    seg_d          = wdata;
        if (wen && sel_led_lo) led_d[15:0]    = wdata[15:0];
        if (wen && sel_led_hi) led_d[23:16]   = wdata[7:0];

        // Read data reflects pre-edge state, so a same-cycle write is not forwarded
        rdata_d = '0;
        if (sel_seg)                  rdata_d = seg_q;
        else if (sel_led_lo || sel_led_hi) rdata_d = {8'b0, led_q};
        else if (sel_sw)              rdata_d = {8'b0, device_sw};
        else if (sel_btn)             rdata_d = {22'b0, evt_q, btn_db};

        // Clearing only affects bits already returned; a fresh rise always sets
        evt_d = (btn_rd ? '0 : evt_q) | btn_rise;

        scan_cnt_d = scan_cnt_q + SW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_MAX) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
        end

        // Enable and segments come from the same next-state index, so they stay paired
        seg_en_d  = ~(8'd1 << idx_d);
        seg_out_d = hex7(seg_d[{idx_d, 2'b00} +: 4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            led_q      <= '0;
            rdata_q    <= '0;
            evt_q      <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_en_q   <= 8'hFE;
            seg_out_q  <= 8'hC0;
        end else begin
            seg_q      <= seg_d;
            led_q      <= led_d;
            rdata_q    <= rdata_d;
            evt_q      <= evt_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_en_q   <= seg_en_d;
            seg_out_q  <= seg_out_d;
        end
    end

    assign rdata      = rdata_q;
    assign device_led = led_q;
    assign seg_en     = seg_en_q;
    assign seg_out    = seg_out_q;
endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: register access, scan sequence, debounce timing,
// event clear-on-read with set priority, address decode and async reset.

module tb_io_responder;
    localparam int SCAN = 4;
    localparam int DEB  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr = '0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        hit;
    logic [23:0] device_sw = '0;
    logic [4:0]  device_button = '0;
    logic [23:0] device_led;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;

    always #5 clk = ~clk;

    io_responder #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr          (addr),
        .wen           (wen),
        .wdata         (wdata),
        .rdata         (rdata),
        .hit           (hit),
        .device_sw     (device_sw),
        .device_button (device_button),
        .device_led    (device_led),
        .seg_en        (seg_en),
        .seg_out       (seg_out)
    );

    int nchecks = 0;
    int nerr = 0;
    int cyc;

    // Edges seen since reset release; the scan position follows from it
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wen = 1'b1;
        step();
        wen = 1'b0; addr = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr = a; wen = 1'b0;
        step();
        chk(tag, rdata, exp);
    endtask

    logic [31:0] seg_val;
    logic [2:0]  idx;
    logic [7:0]  exp_en;

    initial begin
        // Async reset with no clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_seg_en", {24'b0, seg_en}, 32'h0000_00FE);
        chk("rst_seg_out", {24'b0, seg_out}, 32'h0000_00C0);
        chk("rst_led", {8'b0, device_led}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        step(); step();
        rst_n = 1'b1;

        // Register writes and readback
        seg_val = 32'h1234_5678;
        wr(32'hFFFF_F000, seg_val);
        wr(32'hFFFF_F060, 32'h1234_BEEF);
        wr(32'hFFFF_F062, 32'hFFFF_FF5A);
        rd(32'hFFFF_F062, 32'h005A_BEEF, "wr_then_rd_led_hi");
        chk("led_value", {8'b0, device_led}, 32'h005A_BEEF);
        rd(32'hFFFF_F060, 32'h005A_BEEF, "rd_led_lo");
        rd(32'hFFFF_F000, 32'h1234_5678, "rd_seg");

        // Scan walks all 8 digits and wraps
        addr = '0;
        for (int i = 0; i < 36; i++) begin
            step();
            idx = 3'((cyc / SCAN) % 8);
            exp_en = ~(8'd1 << idx);
            chk("scan_en", {24'b0, seg_en}, {24'b0, exp_en});
            chk("scan_out", {24'b0, seg_out}, {24'b0, hex_tbl[(seg_val >> (4 * idx)) & 32'hF]});
        end

        // SEG write appears on the scanned digit
        seg_val = 32'hFEDC_BA90;
        wr(32'hFFFF_F000, seg_val);
        step();
        idx = 3'((cyc / SCAN) % 8);
        chk("seg_update", {24'b0, seg_out}, {24'b0, hex_tbl[(seg_val >> (4 * idx)) & 32'hF]});

        // Switches and decode misses
        device_sw = 24'hA5C33C;
        rd(32'hFFFF_F070, 32'h00A5_C33C, "rd_sw");
        addr = 32'hFFFF_F074; #1;
        chk("hit_miss", {31'b0, hit}, 32'h0);
        rd(32'hFFFF_F074, 32'h0, "rd_miss");
        addr = 32'hFFFF_F078; #1;
        chk("hit_btn", {31'b0, hit}, 32'h1);
        addr = 32'hFFFF_F062; #1;
        chk("hit_led_hi", {31'b0, hit}, 32'h1);
        wr(32'hFFFF_F070, 32'hFFFF_FFFF);
        wr(32'hFFFF_F074, 32'hFFFF_FFFF);
        rd(32'hFFFF_F060, 32'h005A_BEEF, "ignored_writes_led");
        rd(32'hFFFF_F000, seg_val, "ignored_writes_seg");

        // Bounce button[2], then hold high; db rises on edge 10, seen in rdata at 11
        addr = 32'hFFFF_F078;
        for (int i = 0; i < 4; i++) begin
            device_button[2] = (i % 2 == 0);
            step();
            chk("bounce_btn", rdata, 32'h0);
        end
        device_button[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("debounce_k%0d", k), rdata,
                (k <= 10) ? 32'h0 : (k == 11) ? 32'h084 : 32'h004);
        end

        // Set wins over a clearing read on the same edge
        addr = 32'hFFFF_F070;
        device_button[0] = 1'b1;
        repeat (12) step();
        device_button[0] = 1'b0;
        repeat (12) step();
        device_button[0] = 1'b1;
        repeat (9) step();
        addr = 32'hFFFF_F078;
        step();
        chk("setwin_read", rdata, 32'h024);
        step();
        chk("setwin_kept", rdata, 32'h025);
        step();
        chk("setwin_cleared", rdata, 32'h005);

        // Reset mid-scan and mid-debounce
        wr(32'hFFFF_F060, 32'h0000_FFFF);
        wr(32'hFFFF_F062, 32'h0000_00FF);
        chk("led_all_on", {8'b0, device_led}, 32'h00FF_FFFF);
        for (int i = 0; i < 40 && ((cyc / SCAN) % 8) != 3; i++) step();
        chk("pre_rst_digit3", {24'b0, seg_en}, 32'h0000_00F7);
        device_button[1] = 1'b1;
        step(); step(); step();
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_led", {8'b0, device_led}, 32'h0);
        chk("mid_rst_seg_en", {24'b0, seg_en}, 32'h0000_00FE);
        chk("mid_rst_seg_out", {24'b0, seg_out}, 32'h0000_00C0);
        chk("mid_rst_rdata", rdata, 32'h0);
        #2 rst_n = 1'b1;
        rd(32'hFFFF_F078, 32'h0, "post_rst_btn");
        rd(32'hFFFF_F000, 32'h0, "post_rst_seg");
        rd(32'hFFFF_F060, 32'h0, "post_rst_led");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
